// File: rtl/rf_sequencer.sv
// Register-file command sequencer for RNBIP-2 register instructions.
// Accepts one decoded instruction at a time and drives enable/mux/index commands.
module rf_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    input  logic       or2_valid,
    input  logic       alu_done,
    output logic       alu_start,
    output logic [1:0] rf_enab,
    output logic [1:0] rf_mux_sel,
    output logic [2:0] rf_seg,
    output logic       done,
    output logic       err,
    output logic [7:0] retire_cnt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_EXEC,
        S_IMM_WAIT,
        S_READ,
        S_ALU_START,
        S_ALU_WAIT,
        S_ALU_WB,
        S_CLEAR,
        S_ERR
    } state_t;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_MOV_N0 = 3'b001;
    localparam logic [2:0] OP_MOV_0N = 3'b010;
    localparam logic [2:0] OP_MVI    = 3'b011;
    localparam logic [2:0] OP_ALU    = 3'b100;
    localparam logic [2:0] OP_CLR    = 3'b101;

    localparam logic [1:0] EN_CLEAR = 2'b00;
    localparam logic [1:0] EN_WRITE = 2'b01;
    localparam logic [1:0] EN_IDLE  = 2'b10;
    localparam logic [1:0] EN_READ  = 2'b11;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] rn_q, rn_d;
    logic [7:0] wait_q, wait_d;
    logic [7:0] retire_q, retire_d;

    // Bits [4:3] of the instruction carry no meaning for this block.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[4:3];

    assign instr_ready = (state_q == S_IDLE) && !reset;
    assign retire_cnt  = retire_q;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        op_d     = op_q;
        rn_d     = rn_q;
        wait_d   = wait_q;
        retire_d = retire_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d = instr[7:5];
                    rn_d = instr[2:0];
                    case (instr[7:5])
                        OP_NOP, OP_MOV_N0, OP_MOV_0N: state_d = S_EXEC;
                        OP_MVI: begin
                            state_d = S_IMM_WAIT;
                            wait_d  = 8'd0;
                        end
                        OP_ALU:  state_d = S_READ;
                        OP_CLR:  state_d = S_CLEAR;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_IMM_WAIT: begin
                wait_d = wait_q + 8'd1;
                // The awaited input wins over the timeout on the last wait cycle.
                if (or2_valid)                state_d = S_EXEC;
                else if (wait_q == WAIT_LAST) state_d = S_ERR;
            end
            S_READ: begin
                state_d = S_ALU_START;
                wait_d  = 8'd0;
            end
            S_ALU_START: state_d = alu_done ? S_ALU_WB : S_ALU_WAIT;
            S_ALU_WAIT: begin
                wait_d = wait_q + 8'd1;
                if (alu_done)                 state_d = S_ALU_WB;
                else if (wait_q == WAIT_LAST) state_d = S_ERR;
            end
            S_EXEC, S_ALU_WB, S_CLEAR, S_ERR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Counted on entry so the count already includes the instruction retiring this cycle.
        if (state_d == S_EXEC || state_d == S_ALU_WB || state_d == S_CLEAR)
            retire_d = retire_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 3'd0;
            rn_q     <= 3'd0;
            wait_q   <= 8'd0;
            retire_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rn_q     <= rn_d;
            wait_q   <= wait_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        rf_enab    = EN_IDLE;
        rf_mux_sel = 2'b00;
        rf_seg     = 3'b000;
        alu_start  = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            S_EXEC: begin
                done = 1'b1;
                case (op_q)
                    OP_MOV_N0: begin
                        rf_enab    = EN_WRITE;
                        rf_mux_sel = 2'b00;
                        rf_seg     = rn_q;
                    end
                    OP_MOV_0N: begin
                        rf_enab    = EN_WRITE;
                        rf_mux_sel = 2'b01;
                        rf_seg     = rn_q;
                    end
                    OP_MVI: begin
                        rf_enab    = EN_WRITE;
                        rf_mux_sel = 2'b10;
                        rf_seg     = rn_q;
                    end
                    default: ;
                endcase
            end
            S_READ: begin
                rf_enab = EN_READ;
                rf_seg  = rn_q;
            end
            S_ALU_START: alu_start = 1'b1;
            S_ALU_WB: begin
                rf_enab    = EN_WRITE;
                rf_mux_sel = 2'b11;
                done       = 1'b1;
            end
            S_CLEAR: begin
                rf_enab = EN_CLEAR;
                done    = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: directed cases plus random instructions
// compared cycle by cycle against an instruction-level expected-command model.
module tb_rf_sequencer;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       or2_valid;
    logic       alu_done;
    logic       alu_start;
    logic [1:0] rf_enab;
    logic [1:0] rf_mux_sel;
    logic [2:0] rf_seg;
    logic       done;
    logic       err;
    logic [7:0] retire_cnt;

    rf_sequencer #(.TIMEOUT(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_ready(instr_ready),
        .or2_valid  (or2_valid),
        .alu_done   (alu_done),
        .alu_start  (alu_start),
        .rf_enab    (rf_enab),
        .rf_mux_sel (rf_mux_sel),
        .rf_seg     (rf_seg),
        .done       (done),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    // One expected cycle: command outputs plus how the bench drives the wait inputs.
    typedef struct {
        logic [1:0] enab;
        logic [1:0] mux;
        logic [2:0] seg;
        logic       start;
        logic       dn;
        logic       er;
        bit         or2_care;
        logic       or2;
        bit         alu_care;
        logic       alu;
    } cyc_t;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_retire = 8'd0;

    function automatic cyc_t mk(input logic [1:0] en, input logic [1:0] mx, input logic [2:0] sg,
                                input logic st, input logic dn, input logic er);
        cyc_t c;
        c.enab = en; c.mux = mx; c.seg = sg;
        c.start = st; c.dn = dn; c.er = er;
        c.or2_care = 1'b0; c.or2 = 1'b0;
        c.alu_care = 1'b0; c.alu = 1'b0;
        return c;
    endfunction

    function automatic cyc_t idle_c();
        return mk(2'b10, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compares {ready, enab, mux, seg, alu_start, done, err, retire_cnt} as one word.
    task automatic check_outs(input string tag, input cyc_t e, input logic rdy);
        check(tag,
              {13'd0, instr_ready, rf_enab, rf_mux_sel, rf_seg, alu_start, done, err, retire_cnt},
              {13'd0, rdy, e.enab, e.mux, e.seg, e.start, e.dn, e.er, exp_retire});
    endtask

    // Called just after a rising edge: drive this cycle, check, advance to the next cycle.
    task automatic drive_cycle(input string tag, input cyc_t e, input logic rdy);
        or2_valid = e.or2_care ? e.or2 : 1'($urandom);
        alu_done  = e.alu_care ? e.alu : 1'($urandom);
        #1;
        check_outs(tag, e, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle(input string tag);
        reset       = 1'b1;
        instr_valid = 1'($urandom);
        instr       = 8'($urandom);
        or2_valid   = 1'($urandom);
        alu_done    = 1'($urandom);
        #1;
        check_outs(tag, idle_c(), 1'b0);
        @(posedge clk);
        #1;
    endtask

    // d: for MVI, the IMM_WAIT cycle (1-based) in which or2_valid rises; for ALU, the cycle
    // counted from ALU_START (=1) in which alu_done rises. Out-of-window values mean "never".
    task automatic run_instr(input logic [7:0] ins, input int d);
        cyc_t       q[$];
        cyc_t       e;
        logic [2:0] op;
        logic [2:0] rn;
        op = ins[7:5];
        rn = ins[2:0];
        case (op)
            3'd0: q.push_back(mk(2'b10, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0));
            3'd1: q.push_back(mk(2'b01, 2'b00, rn,   1'b0, 1'b1, 1'b0));
            3'd2: q.push_back(mk(2'b01, 2'b01, rn,   1'b0, 1'b1, 1'b0));
            3'd3: begin
                for (int k = 1; k <= T; k++) begin
                    e = idle_c();
                    e.or2_care = 1'b1;
                    e.or2 = (k == d);
                    q.push_back(e);
                    if (k == d) break;
                end
                if (d >= 1 && d <= T) q.push_back(mk(2'b01, 2'b10, rn, 1'b0, 1'b1, 1'b0));
                else                  q.push_back(mk(2'b10, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1));
            end
            3'd4: begin
                q.push_back(mk(2'b11, 2'b00, rn, 1'b0, 1'b0, 1'b0));
                e = mk(2'b10, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0);
                e.alu_care = 1'b1;
                e.alu = (d == 1);
                q.push_back(e);
                if (d != 1) begin
                    for (int j = 1; j <= T; j++) begin
                        e = idle_c();
                        e.alu_care = 1'b1;
                        e.alu = (d == j + 1);
                        q.push_back(e);
                        if (d == j + 1) break;
                    end
                end
                if (d >= 1 && d <= T + 1) q.push_back(mk(2'b01, 2'b11, 3'd0, 1'b0, 1'b1, 1'b0));
                else                      q.push_back(mk(2'b10, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1));
            end
            3'd5:    q.push_back(mk(2'b00, 2'b00, 3'd0, 1'b0, 1'b1, 1'b0));
            default: q.push_back(mk(2'b10, 2'b00, 3'd0, 1'b0, 1'b0, 1'b1));
        endcase

        instr_valid = 1'b1;
        instr       = ins;
        drive_cycle($sformatf("accept_%02h", ins), idle_c(), 1'b1);
        foreach (q[i]) begin
            // Busy-time instructions must be ignored.
            instr_valid = 1'($urandom);
            instr       = 8'($urandom);
            if (q[i].dn) exp_retire++;
            drive_cycle($sformatf("instr_%02h_d%0d_c%0d", ins, d, i + 1), q[i], 1'b0);
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        cyc_t       e;
        logic [7:0] ins;
        int         d;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 8'd0;
        or2_valid   = 1'b0;
        alu_done    = 1'b0;
        @(posedge clk);
        #1;
        reset_cycle("reset_c1");
        reset_cycle("reset_c2");
        reset       = 1'b0;
        instr_valid = 1'b0;
        drive_cycle("post_reset_ready", idle_c(), 1'b1);

        run_instr(8'h25, 0);
        run_instr(8'h83, 4);
        run_instr(8'h66, 0);
        run_instr(8'h66, T);
        run_instr(8'hE0, 0);
        run_instr(8'hA0, 0);
        run_instr(8'h81, 1);
        run_instr(8'h87, T + 1);
        run_instr(8'h82, T + 2);
        run_instr(8'h79, 1);
        run_instr(8'h4A, 0);
        run_instr(8'h1F, 0);
        run_instr(8'hDB, 0);

        for (int n = 0; n < 80; n++) begin
            ins = 8'($urandom);
            d   = (ins[7:5] == 3'd3) ? int'($urandom_range(0, T + 2)) : int'($urandom_range(1, T + 3));
            run_instr(ins, d);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
                instr_valid = 1'b0;
                instr       = 8'($urandom);
                drive_cycle("gap_idle", idle_c(), 1'b1);
            end
        end

        // Reset while waiting on the ALU: the pending write-back must be dropped.
        instr_valid = 1'b1;
        instr       = 8'h81;
        drive_cycle("mid_accept", idle_c(), 1'b1);
        instr_valid = 1'b0;
        e = mk(2'b11, 2'b00, 3'd1, 1'b0, 1'b0, 1'b0);
        e.alu_care = 1'b1;
        drive_cycle("mid_read", e, 1'b0);
        e = mk(2'b10, 2'b00, 3'd0, 1'b1, 1'b0, 1'b0);
        e.alu_care = 1'b1;
        drive_cycle("mid_start", e, 1'b0);
        e = idle_c();
        e.alu_care = 1'b1;
        drive_cycle("mid_wait", e, 1'b0);
        reset     = 1'b1;
        alu_done  = 1'b1;
        or2_valid = 1'b0;
        #1;
        check_outs("mid_reset_ready_low", idle_c(), 1'b0);
        @(posedge clk);
        #1;
        exp_retire = 8'd0;
        check_outs("mid_reset_applied", idle_c(), 1'b0);
        reset = 1'b0;
        e = idle_c();
        e.alu_care = 1'b1;
        e.alu = 1'b1;
        drive_cycle("mid_after_c1", e, 1'b1);
        drive_cycle("mid_after_c2", e, 1'b1);

        repeat (256) run_instr(8'h00, 0);
        check("retire_wrap", {24'd0, retire_cnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
